// File: rtl/decision_unit.sv
// Decision unit: on each start, scans the bin's variable-state vector one
// variable per cycle for the lowest-index unassigned variable. It then either
// issues a one-cycle decision and bumps the decision level, or reports that
// every variable is assigned. Backtrack logic may load the level at any time.
module decision_unit #(
    parameter int NUM_VARS  = 8,
    parameter int WIDTH_VAR = 3,
    parameter int WIDTH_LVL = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_decision_i,
    output logic                  done_decision_o,
    output logic                  all_c_is_sat_o,
    output logic [WIDTH_LVL-1:0]  cur_lvl_o,
    input  logic [2*NUM_VARS-1:0] var_state_i,
    input  logic [NUM_VARS-1:0]   var_phase_i,
    output logic                  apply_decision_o,
    output logic [WIDTH_VAR-1:0]  decided_var_o,
    output logic                  decided_value_o,
    input  logic                  load_lvl_i,
    input  logic [WIDTH_LVL-1:0]  bkt_lvl_i,
    output logic                  lvl_overflow_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        FOUND  = 2'd2,
        ALLSAT = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    logic [WIDTH_VAR-1:0] idx;
    logic [1:0]           cur_var_state;
    logic                 cur_unassigned;
    logic                 last_idx;
    logic                 found_now;

    logic                 done_nxt;
    logic                 apply_nxt;
    logic                 allsat_nxt;
    logic [WIDTH_VAR-1:0] var_nxt;
    logic                 value_nxt;
    logic [WIDTH_LVL-1:0] lvl_base;
    logic [WIDTH_LVL-1:0] lvl_nxt;
    logic                 ovf_nxt;

    // The variable under examination is sampled live; encoding 11 counts as assigned.
    assign cur_var_state  = var_state_i[{idx, 1'b0} +: 2];
    assign cur_unassigned = (cur_var_state == 2'b00);
    assign last_idx       = (idx == WIDTH_VAR'(NUM_VARS - 1));
    assign found_now      = (state == SCAN) && cur_unassigned;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; starts outside IDLE are simply ignored.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_decision_i) next_state = SCAN;
            SCAN: begin
                if (cur_unassigned) begin
                    next_state = FOUND;
                end else if (last_idx) begin
                    next_state = ALLSAT;
                end
            end
            FOUND:   next_state = IDLE;
            ALLSAT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Scan index: restarts at 0 on an accepted start, advances past assigned variables.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx <= '0;
        end else if (state == IDLE && start_decision_i) begin
            idx <= '0;
        end else if (state == SCAN && !cur_unassigned && !last_idx) begin
            idx <= idx + 1'b1;
        end
    end

    // Output decode: next values for the registered outputs, so every pulse
    // lines up with the cycle the FSM sits in FOUND or ALLSAT.
    always_comb begin
        done_nxt   = (next_state == FOUND) || (next_state == ALLSAT);
        apply_nxt  = (next_state == FOUND);
        allsat_nxt = all_c_is_sat_o;
        var_nxt    = decided_var_o;
        value_nxt  = decided_value_o;
        if (state == IDLE && start_decision_i) begin
            allsat_nxt = 1'b0;
        end else if (next_state == ALLSAT) begin
            allsat_nxt = 1'b1;
        end
        if (found_now) begin
            var_nxt   = idx;
            value_nxt = var_phase_i[idx];
        end
    end

    // Level arithmetic: a backtrack load replaces the base, a decision adds one
    // on top of it, and an increment at the top saturates and flags overflow.
    always_comb begin
        lvl_base = load_lvl_i ? bkt_lvl_i : cur_lvl_o;
        lvl_nxt  = lvl_base;
        ovf_nxt  = lvl_overflow_o;
        if (found_now) begin
            if (&lvl_base) begin
                ovf_nxt = 1'b1;
            end else begin
                lvl_nxt = lvl_base + 1'b1;
            end
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_decision_o  <= 1'b0;
            apply_decision_o <= 1'b0;
            all_c_is_sat_o   <= 1'b0;
            decided_var_o    <= '0;
            decided_value_o  <= 1'b0;
            cur_lvl_o        <= '0;
            lvl_overflow_o   <= 1'b0;
        end else begin
            done_decision_o  <= done_nxt;
            apply_decision_o <= apply_nxt;
            all_c_is_sat_o   <= allsat_nxt;
            decided_var_o    <= var_nxt;
            decided_value_o  <= value_nxt;
            cur_lvl_o        <= lvl_nxt;
            lvl_overflow_o   <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_decision_unit.sv
// Self-checking bench for decision_unit: directed cases plus randomized
// decision runs checked against a behavioural model of the scan result.
module tb_decision_unit;

    localparam int NV = 8;
    localparam int WV = 3;
    localparam int WL = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_decision_i;
    logic          done_decision_o;
    logic          all_c_is_sat_o;
    logic [WL-1:0] cur_lvl_o;
    logic [2*NV-1:0] var_state_i;
    logic [NV-1:0] var_phase_i;
    logic          apply_decision_o;
    logic [WV-1:0] decided_var_o;
    logic          decided_value_o;
    logic          load_lvl_i;
    logic [WL-1:0] bkt_lvl_i;
    logic          lvl_overflow_o;

    int compared   = 0;
    int mismatched = 0;

    int unsigned m_lvl;
    bit          m_ovf;
    bit          m_allsat;
    int unsigned m_var;
    bit          m_val;

    decision_unit #(.NUM_VARS(NV), .WIDTH_VAR(WV), .WIDTH_LVL(WL)) dut (
        .clk              (clk),
        .rst              (rst),
        .start_decision_i (start_decision_i),
        .done_decision_o  (done_decision_o),
        .all_c_is_sat_o   (all_c_is_sat_o),
        .cur_lvl_o        (cur_lvl_o),
        .var_state_i      (var_state_i),
        .var_phase_i      (var_phase_i),
        .apply_decision_o (apply_decision_o),
        .decided_var_o    (decided_var_o),
        .decided_value_o  (decided_value_o),
        .load_lvl_i       (load_lvl_i),
        .bkt_lvl_i        (bkt_lvl_i),
        .lvl_overflow_o   (lvl_overflow_o)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic modelReset();
        m_lvl    = 0;
        m_ovf    = 1'b0;
        m_allsat = 1'b0;
        m_var    = 0;
        m_val    = 1'b0;
    endtask

    task automatic checkHeld(input string tag);
        checkOutput({tag, "_done"},   done_decision_o, 0);
        checkOutput({tag, "_apply"},  apply_decision_o, 0);
        checkOutput({tag, "_allsat"}, all_c_is_sat_o, m_allsat);
        checkOutput({tag, "_var"},    decided_var_o, m_var);
        checkOutput({tag, "_val"},    decided_value_o, m_val);
        checkOutput({tag, "_lvl"},    cur_lvl_o, m_lvl);
        checkOutput({tag, "_ovf"},    lvl_overflow_o, m_ovf);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_done"},   done_decision_o, 0);
        checkOutput({tag, "_apply"},  apply_decision_o, 0);
        checkOutput({tag, "_allsat"}, all_c_is_sat_o, 0);
        checkOutput({tag, "_var"},    decided_var_o, 0);
        checkOutput({tag, "_val"},    decided_value_o, 0);
        checkOutput({tag, "_lvl"},    cur_lvl_o, 0);
        checkOutput({tag, "_ovf"},    lvl_overflow_o, 0);
    endtask

    task automatic loadLevel(input logic [WL-1:0] bkt);
        load_lvl_i = 1'b1;
        bkt_lvl_i  = bkt;
        tick();
        load_lvl_i = 1'b0;
        m_lvl = bkt;
        checkHeld("load");
    endtask

    // One decision handshake with stable var_state; optional level load in the
    // cycle the unassigned variable is found, optional stray starts mid-scan.
    task automatic applyStimulus(input logic [2*NV-1:0] vs, input logic [NV-1:0] ph,
                                 input bit load_in_find, input logic [WL-1:0] bkt,
                                 input bit spurious);
        int k;
        int exp_lat;
        int cyc;
        int unsigned base;
        k = NV;
        for (int i = NV - 1; i >= 0; i--) begin
            if (vs[2*i +: 2] == 2'b00) k = i;
        end
        exp_lat = (k < NV) ? k + 2 : NV + 1;

        var_state_i      = vs;
        var_phase_i      = ph;
        start_decision_i = 1'b1;
        tick();
        start_decision_i = 1'b0;
        cyc = 1;
        m_allsat = 1'b0;
        checkOutput("allsat_cleared", all_c_is_sat_o, 0);

        while (!done_decision_o && cyc < 30) begin
            load_lvl_i       = load_in_find && (k < NV) && (cyc == k + 1);
            bkt_lvl_i        = bkt;
            start_decision_i = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            cyc++;
        end
        load_lvl_i       = 1'b0;
        start_decision_i = 1'b0;

        if (k < NV) begin
            base = (load_in_find) ? int'(bkt) : m_lvl;
            if (base == (1 << WL) - 1) begin
                m_lvl = base;
                m_ovf = 1'b1;
            end else begin
                m_lvl = base + 1;
            end
            m_var = k;
            m_val = ph[k];
        end else begin
            m_allsat = 1'b1;
        end

        checkOutput("latency",    cyc, exp_lat);
        checkOutput("done_pulse", done_decision_o, 1);
        checkOutput("apply",      apply_decision_o, (k < NV) ? 1 : 0);
        checkOutput("allsat",     all_c_is_sat_o, m_allsat);
        checkOutput("dec_var",    decided_var_o, m_var);
        checkOutput("dec_val",    decided_value_o, m_val);
        checkOutput("lvl",        cur_lvl_o, m_lvl);
        checkOutput("ovf",        lvl_overflow_o, m_ovf);

        tick();
        checkHeld("after_done");
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("no_extra_done", done_decision_o, 0);
        end
    endtask

    // Random var_state vector whose first unassigned index is k (k == NV: none).
    function automatic logic [2*NV-1:0] randVector(input int k);
        logic [2*NV-1:0] v;
        v = '0;
        for (int i = 0; i < NV; i++) begin
            if (i < k)       v[2*i +: 2] = 2'($urandom_range(1, 3));
            else if (i == k) v[2*i +: 2] = 2'b00;
            else             v[2*i +: 2] = 2'($urandom_range(0, 3));
        end
        return v;
    endfunction

    initial begin
        rst              = 1'b0;
        start_decision_i = 1'b0;
        var_state_i      = '0;
        var_phase_i      = '0;
        load_lvl_i       = 1'b0;
        bkt_lvl_i        = '0;
        modelReset();
        tick();
        tick();
        checkAllZero("reset");
        rst = 1'b1;
        tick();

        // First variable unassigned, phase 1.
        applyStimulus(16'h0000, 8'h01, 1'b0, '0, 1'b0);
        // Variables 0..4 assigned, variable 5 unassigned with phase 0.
        applyStimulus(16'hA266, 8'hDF, 1'b0, '0, 1'b0);
        // Everything assigned, one variable encoded 11.
        applyStimulus(16'h55D5, 8'hFF, 1'b0, '0, 1'b0);
        // Level load while idle.
        loadLevel(16'd5);
        // Load coinciding with the decision increment.
        applyStimulus(16'h001A, 8'h04, 1'b1, 16'd9, 1'b0);
        // Stray starts during the scan.
        applyStimulus(16'h0AAA, 8'h40, 1'b0, '0, 1'b1);

        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 4) == 0) loadLevel(WL'($urandom_range(0, 1000)));
            applyStimulus(randVector($urandom_range(0, NV)), NV'($urandom),
                          1'($urandom_range(0, 1)), WL'($urandom_range(0, 1000)),
                          1'($urandom_range(0, 1)));
        end

        // Saturation at the top level; the flag is sticky across loads.
        loadLevel(16'hFFFF);
        applyStimulus(16'hFF00, 8'h0F, 1'b0, '0, 1'b0);
        applyStimulus(16'h0000, 8'h00, 1'b0, '0, 1'b0);
        loadLevel(16'd3);
        applyStimulus(16'h0006, 8'h02, 1'b1, 16'hFFFF, 1'b0);

        // Asynchronous reset in the middle of a scan (index 3 under examination).
        var_state_i      = 16'h2AAA;
        start_decision_i = 1'b1;
        tick();
        start_decision_i = 1'b0;
        tick();
        tick();
        tick();
        #2;
        rst = 1'b0;
        #1;
        modelReset();
        checkAllZero("async_reset");
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            checkOutput("no_done_after_reset", done_decision_o, 0);
        end
        checkHeld("post_reset");
        applyStimulus(16'h0000, 8'h01, 1'b0, '0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
